// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the I/D cache miss paths, the shared memory port and the arbiter.
// The master modport is the arbiter side; slave is the cache/memory environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              i_read_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic [DATA_W-1:0] i_rdata_o;
  logic              i_ready_o;
  logic              d_read_i;
  logic              d_write_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_ready_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;
  logic              busy_o;

  modport master (
    input  i_read_i, i_addr_i, d_read_i, d_write_i, d_addr_i, d_wdata_i,
           mem_rdata_i, mem_ready_i,
    output i_rdata_o, i_ready_o, d_rdata_o, d_ready_o,
           mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, busy_o
  );

  modport slave (
    output i_read_i, i_addr_i, d_read_i, d_write_i, d_addr_i, d_wdata_i,
           mem_rdata_i, mem_ready_i,
    input  i_rdata_o, i_ready_o, d_rdata_o, d_ready_o,
           mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for the external memory port, D-side priority with
// a starvation bound that forces an I-cache refill after STARVE_LIMIT D grants.
//
// state  | meaning
// IDLE   | arbitrate between I and D requests every cycle
// SERV_D | D-cache read or write-back in flight on the memory port
// SERV_I | I-cache line read in flight on the memory port
// DONE   | one quiet cycle so the served requester can drop its request
module mem_port_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  mem_port_arbiter_if.master  bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, SERV_D, SERV_I, DONE} state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  starveCnt, starveCntNext;
  logic              memRead, memReadNext;
  logic              memWrite, memWriteNext;
  logic [ADDR_W-1:0] memAddr, memAddrNext;
  logic [DATA_W-1:0] memWdata, memWdataNext;
  logic [DATA_W-1:0] iRdata, iRdataNext;
  logic [DATA_W-1:0] dRdata, dRdataNext;
  logic              iReady, iReadyNext;
  logic              dReady, dReadyNext;

  logic dReq, grantD, grantI;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      starveCnt <= '0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      iRdata    <= '0;
      dRdata    <= '0;
      iReady    <= 1'b0;
      dReady    <= 1'b0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveCntNext;
      memRead   <= memReadNext;
      memWrite  <= memWriteNext;
      memAddr   <= memAddrNext;
      memWdata  <= memWdataNext;
      iRdata    <= iRdataNext;
      dRdata    <= dRdataNext;
      iReady    <= iReadyNext;
      dReady    <= dReadyNext;
    end
  end

  always_comb begin
    stateNext     = state;
    starveCntNext = starveCnt;
    memReadNext   = memRead;
    memWriteNext  = memWrite;
    memAddrNext   = memAddr;
    memWdataNext  = memWdata;
    iRdataNext    = iRdata;
    dRdataNext    = dRdata;
    iReadyNext    = 1'b0;
    dReadyNext    = 1'b0;

    dReq   = bus.d_read_i | bus.d_write_i;
    grantD = 1'b0;
    grantI = 1'b0;

    case (state)
      IDLE: begin
        grantD = dReq & (!bus.i_read_i | (starveCnt < LIMIT));
        grantI = !grantD & bus.i_read_i;
        if (grantD) begin
          stateNext    = SERV_D;
          memAddrNext  = bus.d_addr_i;
          memWdataNext = bus.d_wdata_i;
          // A simultaneous read and write-back request runs as the write.
          memWriteNext = bus.d_write_i;
          memReadNext  = !bus.d_write_i;
          if (bus.i_read_i && (starveCnt < LIMIT))
            starveCntNext = starveCnt + CNT_W'(1);
        end else if (grantI) begin
          stateNext     = SERV_I;
          memAddrNext   = bus.i_addr_i;
          memReadNext   = 1'b1;
          memWriteNext  = 1'b0;
          starveCntNext = '0;
        end
      end
      SERV_D: begin
        if (bus.mem_ready_i) begin
          stateNext    = DONE;
          memReadNext  = 1'b0;
          memWriteNext = 1'b0;
          dReadyNext   = 1'b1;
          if (memRead)
            dRdataNext = bus.mem_rdata_i;
        end
      end
      SERV_I: begin
        if (bus.mem_ready_i) begin
          stateNext    = DONE;
          memReadNext  = 1'b0;
          memWriteNext = 1'b0;
          iReadyNext   = 1'b1;
          iRdataNext   = bus.mem_rdata_i;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign bus.i_rdata_o   = iRdata;
  assign bus.i_ready_o   = iReady;
  assign bus.d_rdata_o   = dRdata;
  assign bus.d_ready_o   = dReady;
  assign bus.mem_read_o  = memRead;
  assign bus.mem_write_o = memWrite;
  assign bus.mem_addr_o  = memAddr;
  assign bus.mem_wdata_o = memWdata;
  assign bus.busy_o      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected memory transactions are queued when
// requests are raised and checked as the memory port and ready pulses respond.
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  typedef struct {
    logic          isD;
    logic          isWrite;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  txn_t          sb[$];
  int            nTests = 0;
  int            nFail  = 0;
  logic [DW-1:0] lastI  = '0;
  logic [DW-1:0] lastD  = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic isD, input logic isWrite, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
    txn_t t;
    t.isD = isD; t.isWrite = isWrite; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    return t;
  endfunction

  // Pops the next expected transaction, plays memory for it and checks the completion.
  task automatic serveMem(input int delay, input logic dropReq, input logic midChange);
    txn_t t;
    int   waited;
    logic seen;
    if (sb.size() == 0) begin
      chk("sb_empty", DW'(1), DW'(0));
      return;
    end
    t = sb.pop_front();
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 30) begin
      @(negedge clk);
      seen = bus.mem_read_o | bus.mem_write_o;
      if (!seen) waited++;
    end
    chk("strobe_seen", DW'(seen), DW'(1));
    chk("grant_latency", DW'(waited), DW'(0));
    chk("strobe_kind", DW'({bus.mem_read_o, bus.mem_write_o}), DW'({!t.isWrite, t.isWrite}));
    chk("mem_addr", DW'(bus.mem_addr_o), DW'(t.addr));
    if (t.isWrite) chk("mem_wdata", bus.mem_wdata_o, t.wdata);
    chk("busy_serv", DW'(bus.busy_o), DW'(1));
    if (midChange) begin
      bus.d_addr_i  = ~bus.d_addr_i;
      bus.d_wdata_i = ~bus.d_wdata_i;
      bus.d_read_i  = 1'b0;
      bus.d_write_i = 1'b0;
    end
    repeat (delay) begin
      @(negedge clk);
      chk("strobe_held", DW'({bus.mem_read_o, bus.mem_write_o}), DW'({!t.isWrite, t.isWrite}));
      chk("addr_held", DW'(bus.mem_addr_o), DW'(t.addr));
      chk("no_early_ready", DW'({bus.i_ready_o, bus.d_ready_o}), DW'(0));
    end
    bus.mem_rdata_i = t.rdata;
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = ~t.rdata;
    if (t.isD && !t.isWrite) lastD = t.rdata;
    if (!t.isD) lastI = t.rdata;
    chk("ready_pulse", DW'({bus.i_ready_o, bus.d_ready_o}), DW'({!t.isD, t.isD}));
    chk("strobe_drop", DW'({bus.mem_read_o, bus.mem_write_o}), DW'(0));
    chk("i_rdata", bus.i_rdata_o, lastI);
    chk("d_rdata", bus.d_rdata_o, lastD);
    chk("busy_done", DW'(bus.busy_o), DW'(1));
    if (dropReq) begin
      if (t.isD) begin
        bus.d_read_i  = 1'b0;
        bus.d_write_i = 1'b0;
      end else begin
        bus.i_read_i = 1'b0;
      end
    end
    @(negedge clk);
    chk("ready_one_cycle", DW'({bus.i_ready_o, bus.d_ready_o}), DW'(0));
    chk("done_no_strobe", DW'({bus.mem_read_o, bus.mem_write_o}), DW'(0));
    chk("idle_after_done", DW'(bus.busy_o), DW'(0));
    chk("rdata_hold", {bus.i_rdata_o ^ lastI} | {bus.d_rdata_o ^ lastD}, DW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   waited;
    logic seen;

    rst_n           = 1'b0;
    bus.i_read_i    = 1'b0;
    bus.i_addr_i    = '0;
    bus.d_read_i    = 1'b0;
    bus.d_write_i   = 1'b0;
    bus.d_addr_i    = '0;
    bus.d_wdata_i   = '0;
    bus.mem_rdata_i = '0;
    bus.mem_ready_i = 1'b0;

    // Power-on reset
    @(negedge clk);
    chk("por_flags", DW'({bus.i_ready_o, bus.d_ready_o, bus.mem_read_o, bus.mem_write_o, bus.busy_o}), DW'(0));
    chk("por_i_rdata", bus.i_rdata_o, DW'(0));
    chk("por_d_rdata", bus.d_rdata_o, DW'(0));
    chk("por_addr", DW'(bus.mem_addr_o), DW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Stray mem_ready_i while idle
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = {DW{1'b1}};
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    chk("idle_ready_ignored", DW'({bus.i_ready_o, bus.d_ready_o, bus.busy_o}), DW'(0));
    chk("idle_rdata_ignored", bus.i_rdata_o | bus.d_rdata_o, DW'(0));

    // Lone I read
    bus.i_read_i = 1'b1;
    bus.i_addr_i = 28'h0000040;
    sb.push_back(mk(1'b0, 1'b0, 28'h0000040, '0, {16{8'hA5}}));
    serveMem(2, 1'b1, 1'b0);

    // Simultaneous D and I reads, starve count 0
    bus.d_read_i = 1'b1;
    bus.d_addr_i = 28'h0000100;
    bus.i_read_i = 1'b1;
    bus.i_addr_i = 28'h0000200;
    sb.push_back(mk(1'b1, 1'b0, 28'h0000100, '0, 128'h1111_2222_3333_4444_5555_6666_7777_8888));
    sb.push_back(mk(1'b0, 1'b0, 28'h0000200, '0, 128'hDEAD_BEEF_0000_0000_CAFE_F00D_0000_0001));
    serveMem(1, 1'b1, 1'b0);
    chk("starve_after_d", DW'(dut.starveCnt), DW'(1));
    serveMem(0, 1'b1, 1'b0);
    chk("starve_after_i", DW'(dut.starveCnt), DW'(0));

    // Starvation: continuous D traffic with I pending
    bus.d_read_i = 1'b1;
    bus.d_addr_i = 28'h0000300;
    bus.i_read_i = 1'b1;
    bus.i_addr_i = 28'h0000400;
    for (int k = 0; k < 4; k++)
      sb.push_back(mk(1'b1, 1'b0, 28'h0000300, '0, DW'(128'h5000 + k)));
    sb.push_back(mk(1'b0, 1'b0, 28'h0000400, '0, 128'h7777));
    sb.push_back(mk(1'b1, 1'b0, 28'h0000300, '0, 128'h9999));
    for (int k = 0; k < 4; k++) begin
      serveMem(1, 1'b0, 1'b0);
      chk("starve_count", DW'(dut.starveCnt), DW'(k + 1));
    end
    serveMem(1, 1'b1, 1'b0);
    chk("starve_cleared", DW'(dut.starveCnt), DW'(0));
    serveMem(0, 1'b1, 1'b0);
    chk("starve_hold", DW'(dut.starveCnt), DW'(0));

    // Read and write both asserted: write wins, d_rdata untouched
    bus.d_read_i  = 1'b1;
    bus.d_write_i = 1'b1;
    bus.d_addr_i  = 28'h0000500;
    bus.d_wdata_i = 128'h1234;
    sb.push_back(mk(1'b1, 1'b1, 28'h0000500, 128'h1234, 128'hBAD0_BAD0));
    serveMem(1, 1'b1, 1'b0);

    // Requester changes address and drops request after grant
    bus.d_read_i  = 1'b1;
    bus.d_addr_i  = 28'h0ABCDE0;
    bus.d_wdata_i = '0;
    sb.push_back(mk(1'b1, 1'b0, 28'h0ABCDE0, '0, 128'h6666_0000_6666));
    serveMem(2, 1'b0, 1'b1);
    chk("sb_drained", DW'(sb.size()), DW'(0));

    // Reset mid-SERV_D with mem_ready_i pending
    bus.d_read_i = 1'b1;
    bus.d_addr_i = 28'h0000600;
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 30) begin
      @(negedge clk);
      seen = bus.mem_read_o;
      if (!seen) waited++;
    end
    chk("rst_strobe_seen", DW'(seen), DW'(1));
    bus.mem_rdata_i = {DW{1'b1}};
    bus.mem_ready_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_flags", DW'({bus.i_ready_o, bus.d_ready_o, bus.mem_read_o, bus.mem_write_o, bus.busy_o}), DW'(0));
    chk("rst_i_rdata", bus.i_rdata_o, DW'(0));
    chk("rst_d_rdata", bus.d_rdata_o, DW'(0));
    chk("rst_addr_wdata", DW'(bus.mem_addr_o) | bus.mem_wdata_o, DW'(0));
    @(negedge clk);
    bus.d_read_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", DW'({bus.d_ready_o, bus.i_ready_o, bus.busy_o, bus.mem_read_o}), DW'(0));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
